reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp -- multi-port register file with a program-counter alias.
//
// Entries 0..NUM_REGS-2 are stored registers; index NUM_REGS-1 is a PC alias
// that reads as (i_pc_in + PC_OFFSET) and, when written, reports the value on
// o_pc_wr_valid / o_pc_wr_data instead of storing it. After reset a sweep
// clears one stored register per cycle; o_ready rises when the sweep is done.
//
// Optional feature: define REG_FILE_MP_BYPASS_EN to forward same-cycle write
// data to reads of the stored register being written (never for the PC alias).
//
// Ports:
//   i_clk         clock, all state on rising edge
//   i_rst         synchronous active-high reset
//   i_rd_en       read strobe for both read ports
//   i_rd_addr_a   port A read address
//   i_rd_addr_b   port B read address
//   o_rd_data_a   registered port A read data (1-cycle latency)
//   o_rd_data_b   registered port B read data (1-cycle latency)
//   i_wr_en       write strobe
//   i_wr_addr     write address
//   i_wr_data     write data
//   i_pc_in       current program counter
//   o_pc_wr_valid one-cycle pulse when the PC alias is written
//   o_pc_wr_data  last value written to the PC alias
//   o_ready       high once the post-reset clear sweep has finished

module reg_file_mp #(
    parameter int unsigned  DATA_W    = 32,
    parameter int unsigned  NUM_REGS  = 16,
    parameter int unsigned  PC_OFFSET = 8,
    localparam int unsigned ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic [DATA_W-1:0] o_rd_data_b,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [DATA_W-1:0] i_pc_in,
    output logic              o_pc_wr_valid,
    output logic [DATA_W-1:0] o_pc_wr_data,
    output logic              o_ready
);

    localparam int unsigned       NUM_STORED  = NUM_REGS - 1;
    localparam logic [ADDR_W-1:0] PC_ADDR     = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] LAST_STORED = ADDR_W'(NUM_REGS - 2);

    typedef enum logic {StClear, StRun} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_W-1:0]     r_sweep_cnt;
    logic [DATA_W-1:0]     r_regs [NUM_STORED];
    logic [DATA_W-1:0]     r_rd_data_a;
    logic [DATA_W-1:0]     r_rd_data_b;
    logic                  r_pc_wr_valid;
    logic [DATA_W-1:0]     r_pc_wr_data;

    logic                  w_run;
    logic                  w_sweep_done;
    logic                  w_pc_wr;
    logic [NUM_STORED-1:0] w_wr_sel;
    logic [DATA_W-1:0]     w_pc_rd_val;
    logic [DATA_W-1:0]     w_rd_val_a;
    logic [DATA_W-1:0]     w_rd_val_b;

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StClear: if (w_sweep_done) w_state_next = StRun;
            StRun:   w_state_next = StRun;
            default: w_state_next = StClear;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StClear;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sweep_cnt <= '0;
        end else if (!w_run) begin
            r_sweep_cnt <= w_sweep_done ? '0 : r_sweep_cnt + ADDR_W'(1);
        end
    end

    // Decode and read muxes. Addresses with no matching stored entry and not
    // equal to the PC alias fall through to 0.
    always_comb begin
        w_run        = (r_state == StRun);
        w_sweep_done = (r_sweep_cnt == LAST_STORED);
        w_pc_wr      = w_run && i_wr_en && (i_wr_addr == PC_ADDR);
        w_pc_rd_val  = i_pc_in + DATA_W'(PC_OFFSET);
        w_wr_sel     = '0;
        w_rd_val_a   = '0;
        w_rd_val_b   = '0;
        for (int i = 0; i < int'(NUM_STORED); i++) begin
            w_wr_sel[i] = w_run && i_wr_en && (i_wr_addr == ADDR_W'(i));
            if (i_rd_addr_a == ADDR_W'(i)) w_rd_val_a = r_regs[i];
            if (i_rd_addr_b == ADDR_W'(i)) w_rd_val_b = r_regs[i];
        end
`ifdef REG_FILE_MP_BYPASS_EN
        // w_wr_sel only covers stored entries, so the PC alias is never forwarded.
        if ((|w_wr_sel) && (i_rd_addr_a == i_wr_addr)) w_rd_val_a = i_wr_data;
        if ((|w_wr_sel) && (i_rd_addr_b == i_wr_addr)) w_rd_val_b = i_wr_data;
`endif
        if (i_rd_addr_a == PC_ADDR) w_rd_val_a = w_pc_rd_val;
        if (i_rd_addr_b == PC_ADDR) w_rd_val_b = w_pc_rd_val;
    end

    // Storage has no reset of its own; the sweep clears it one entry per cycle.
    // A write in a reset cycle is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < int'(NUM_STORED); i++) begin
                if (!w_run && (r_sweep_cnt == ADDR_W'(i))) begin
                    r_regs[i] <= '0;
                end else if (w_wr_sel[i]) begin
                    r_regs[i] <= i_wr_data;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data_a   <= '0;
            r_rd_data_b   <= '0;
            r_pc_wr_valid <= 1'b0;
            r_pc_wr_data  <= '0;
        end else if (!w_run) begin
            r_rd_data_a   <= '0;
            r_rd_data_b   <= '0;
            r_pc_wr_valid <= 1'b0;
        end else begin
            if (i_rd_en) begin
                r_rd_data_a <= w_rd_val_a;
                r_rd_data_b <= w_rd_val_b;
            end
            r_pc_wr_valid <= w_pc_wr;
            if (w_pc_wr) r_pc_wr_data <= i_wr_data;
        end
    end

    assign o_rd_data_a   = r_rd_data_a;
    assign o_rd_data_b   = r_rd_data_b;
    assign o_pc_wr_valid = r_pc_wr_valid;
    assign o_pc_wr_data  = r_pc_wr_data;
    assign o_ready       = w_run;

endmodule
